// File: rtl/mac_accumulator.sv
// mac_accumulator: sums a stream of sign-magnitude Q7.8 products into a
// 24-bit two's-complement accumulator and presents the saturated
// sign-magnitude result with a valid/ready handshake.
module mac_accumulator #(
  parameter int WIDTH     = 16,
  parameter int MAX_TERMS = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             out_sat,
  output logic             out_trunc
);

  localparam int ACC_W = 24;
  localparam int CNT_W = $clog2(MAX_TERMS) + 1;
  localparam logic [ACC_W-1:0] MAG_MAX = ACC_W'((1 << (WIDTH - 1)) - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_sat;
  logic             r_out_trunc;

  logic [ACC_W-1:0] w_mag;
  logic [ACC_W-1:0] w_term;
  logic [ACC_W-1:0] w_sum;
  logic [ACC_W-1:0] w_abs;
  logic [WIDTH-1:0] w_result;
  logic             w_sat;
  logic             w_accept;
  logic             w_at_limit;
  logic             w_close;

  // A beat is taken whenever the block is not presenting a result.
  assign w_accept   = in_valid && (r_state != HOLD);
  assign w_at_limit = (r_cnt == CNT_W'(MAX_TERMS - 1));
  assign w_close    = w_accept && (in_last || w_at_limit);

  // Decode the incoming sign-magnitude beat and form the running sum;
  // negative zero decodes to zero because negating zero leaves zero.
  always_comb begin
    w_mag  = {{(ACC_W - WIDTH + 1){1'b0}}, in_data[WIDTH-2:0]};
    w_term = in_data[WIDTH-1] ? (ACC_W'(0) - w_mag) : w_mag;
    w_sum  = r_acc + w_term;
  end

  // Convert the closing sum back to sign-magnitude, clamping large magnitudes.
  always_comb begin
    w_abs    = w_sum[ACC_W-1] ? (ACC_W'(0) - w_sum) : w_sum;
    w_sat    = 1'b0;
    w_result = {w_sum[ACC_W-1], w_abs[WIDTH-2:0]};
    if (w_abs > MAG_MAX) begin
      w_sat    = 1'b1;
      w_result = {w_sum[ACC_W-1], {(WIDTH - 1){1'b1}}};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state selection and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b1;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_close) begin
          w_state_next = HOLD;
        end else if (w_accept) begin
          w_state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (w_close) begin
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Accumulator, term counter and registered result; the result registers
  // only change when a sum closes, so they stay stable while held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
      r_out_trunc <= 1'b0;
    end else if (r_state == HOLD) begin
      if (out_ready) begin
        r_acc       <= '0;
        r_cnt       <= '0;
        r_out_data  <= '0;
        r_out_sat   <= 1'b0;
        r_out_trunc <= 1'b0;
      end
    end else if (w_accept) begin
      r_acc <= w_sum;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_close) begin
        r_out_data  <= w_result;
        r_out_sat   <= w_sat;
        r_out_trunc <= ~in_last;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign out_trunc = r_out_trunc;

endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed vector table, hand-written corner sequences
// and a randomized run compared against an arithmetic reference model.
module tb_mac_accumulator;

  localparam int WIDTH     = 16;
  localparam int MAX_TERMS = 256;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [WIDTH-1:0]  in_data;
  logic              in_last;
  logic              in_ready;
  logic              out_valid;
  logic [WIDTH-1:0]  out_data;
  logic              out_ready;
  logic              out_sat;
  logic              out_trunc;

  int checks   = 0;
  int failures = 0;

  // Reference model: sum kept as a plain integer.
  bit          mHolding;
  int          mSum;
  int          mCount;
  logic [15:0] mData;
  bit          mSat;
  bit          mTrunc;

  typedef struct packed {
    logic [2:0]       n;
    logic [3:0][15:0] beats;
    logic [15:0]      expData;
    logic             expSat;
  } vec_t;

  vec_t vecs [8];

  mac_accumulator #(.WIDTH(WIDTH), .MAX_TERMS(MAX_TERMS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_sat   (out_sat),
    .out_trunc (out_trunc)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int decode(input logic [15:0] d);
    int m;
    m = int'(d[14:0]);
    return d[15] ? -m : m;
  endfunction

  task automatic encodeSum(input int s, output logic [15:0] d, output bit sat);
    int mag;
    mag = (s < 0) ? -s : s;
    sat = (mag > 32767);
    if (sat) mag = 32767;
    d = {(s < 0) && (mag != 0), mag[14:0]};
  endtask

  task automatic modelStep();
    if (!rst_n) begin
      mHolding = 0; mSum = 0; mCount = 0; mData = '0; mSat = 0; mTrunc = 0;
    end else if (mHolding) begin
      if (out_ready) mHolding = 0;
    end else if (in_valid) begin
      mSum += decode(in_data);
      mCount++;
      if (in_last || mCount == MAX_TERMS) begin
        encodeSum(mSum, mData, mSat);
        mTrunc   = !in_last;
        mHolding = 1;
        mSum     = 0;
        mCount   = 0;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic l,
                               input logic ordy, input logic rn);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = ordy;
    rst_n     = rn;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic checkAgainstModel();
    checkOutput("rnd in_ready", 32'(in_ready), 32'(!mHolding));
    checkOutput("rnd out_valid", 32'(out_valid), 32'(mHolding));
    if (mHolding) begin
      checkOutput("rnd out_data", 32'(out_data), 32'(mData));
      checkOutput("rnd out_sat", 32'(out_sat), 32'(mSat));
      checkOutput("rnd out_trunc", 32'(out_trunc), 32'(mTrunc));
    end
  endtask

  task automatic releaseResult();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    checkOutput("release out_valid", 32'(out_valid), 32'd0);
    checkOutput("release in_ready", 32'(in_ready), 32'd1);
  endtask

  // Main test sequence.
  initial begin
    logic [15:0] d;
    int          pick;

    vecs[0] = '{n: 3'd1, beats: {16'h0, 16'h0, 16'h0, 16'h04E0}, expData: 16'h04E0, expSat: 1'b0};
    vecs[1] = '{n: 3'd2, beats: {16'h0, 16'h0, 16'h8340, 16'h0180}, expData: 16'h81C0, expSat: 1'b0};
    vecs[2] = '{n: 3'd2, beats: {16'h0, 16'h0, 16'h0001, 16'h7FFF}, expData: 16'h7FFF, expSat: 1'b1};
    vecs[3] = '{n: 3'd2, beats: {16'h0, 16'h0, 16'h8001, 16'hFFFF}, expData: 16'hFFFF, expSat: 1'b1};
    vecs[4] = '{n: 3'd2, beats: {16'h0, 16'h0, 16'h8100, 16'h0100}, expData: 16'h0000, expSat: 1'b0};
    vecs[5] = '{n: 3'd1, beats: {16'h0, 16'h0, 16'h0, 16'h8000}, expData: 16'h0000, expSat: 1'b0};
    vecs[6] = '{n: 3'd3, beats: {16'h0, 16'h0005, 16'h8020, 16'h0010}, expData: 16'h800B, expSat: 1'b0};
    vecs[7] = '{n: 3'd4, beats: {16'hC000, 16'h8000, 16'h4000, 16'h4000}, expData: 16'h4000, expSat: 1'b0};

    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0; rst_n = 1'b0;

    // Reset state.
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_data", 32'(out_data), 32'h0000);
    checkOutput("reset out_sat", 32'(out_sat), 32'd0);
    checkOutput("reset out_trunc", 32'(out_trunc), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      for (int b = 0; b < int'(vecs[i].n); b++) begin
        applyStimulus(1'b1, vecs[i].beats[b], (b == int'(vecs[i].n) - 1), 1'b0, 1'b1);
        if (b < int'(vecs[i].n) - 1)
          checkOutput("vec midsum out_valid", 32'(out_valid), 32'd0);
      end
      checkOutput("vec out_valid", 32'(out_valid), 32'd1);
      checkOutput("vec out_data", 32'(out_data), 32'(vecs[i].expData));
      checkOutput("vec out_sat", 32'(out_sat), 32'(vecs[i].expSat));
      checkOutput("vec out_trunc", 32'(out_trunc), 32'd0);
      releaseResult();
    end

    // Result held under back-pressure while new beats are offered.
    applyStimulus(1'b1, 16'h0300, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 16'h0700, 1'b1, 1'b0, 1'b1);
      checkOutput("hold in_ready", 32'(in_ready), 32'd0);
      checkOutput("hold out_valid", 32'(out_valid), 32'd1);
      checkOutput("hold out_data", 32'(out_data), 32'h0300);
    end
    applyStimulus(1'b1, 16'h0700, 1'b1, 1'b1, 1'b1);
    checkOutput("hold release out_valid", 32'(out_valid), 32'd0);
    checkOutput("hold release in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 16'h0100, 1'b1, 1'b0, 1'b1);
    checkOutput("after hold out_data", 32'(out_data), 32'h0100);
    releaseResult();

    // Reset while a result is held.
    applyStimulus(1'b1, 16'h0100, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    checkOutput("hold reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("hold reset out_data", 32'(out_data), 32'h0000);
    checkOutput("hold reset in_ready", 32'(in_ready), 32'd1);

    // Reset mid-sum discards the partial sum.
    applyStimulus(1'b1, 16'h0100, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'h0100, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0200, 1'b1, 1'b0, 1'b1);
    checkOutput("midsum reset out_data", 32'(out_data), 32'h0200);
    releaseResult();

    // MAX_TERMS beats without a last flag force-close the sum.
    for (int k = 0; k < MAX_TERMS; k++) begin
      applyStimulus(1'b1, 16'h0001, 1'b0, 1'b0, 1'b1);
      if (k == MAX_TERMS - 2)
        checkOutput("limit-1 out_valid", 32'(out_valid), 32'd0);
    end
    checkOutput("limit out_valid", 32'(out_valid), 32'd1);
    checkOutput("limit out_data", 32'(out_data), 32'h0100);
    checkOutput("limit out_trunc", 32'(out_trunc), 32'd1);
    checkOutput("limit out_sat", 32'(out_sat), 32'd0);
    releaseResult();

    // Last flag on exactly the MAX_TERMS-th beat is not a truncation.
    for (int k = 0; k < MAX_TERMS; k++)
      applyStimulus(1'b1, 16'h0001, (k == MAX_TERMS - 1), 1'b0, 1'b1);
    checkOutput("limit last out_data", 32'(out_data), 32'h0100);
    checkOutput("limit last out_trunc", 32'(out_trunc), 32'd0);
    releaseResult();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      pick = int'($urandom_range(0, 9));
      case (pick)
        0:       d = 16'h8000;
        1:       d = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h7FFF;
        2:       d = 16'($urandom);
        default: d = {1'($urandom_range(0, 1)), 3'b000, 12'($urandom)};
      endcase
      applyStimulus(1'($urandom_range(0, 3) != 0), d, ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 1) == 1), ($urandom_range(0, 199) != 0));
      checkAgainstModel();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, sign-magnitude word width (1 sign bit, WIDTH-1 magnitude bits).
REQ-002 The block SHALL have parameter MAX_TERMS, default 256, maximum products per sum; power of two, at most 256.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-005 The block SHALL have port in_valid, input, 1, product beat present.
REQ-006 The block SHALL have port in_data, input, WIDTH, product in sign-magnitude Q7.8 (bit 15 sign, 14:8 integer, 7:0 fraction), as produced by the multiplier stage.
REQ-007 The block SHALL have port in_last, input, 1, beat is final term of current sum.
REQ-008 The block SHALL have port in_ready, output, 1, block accepts a beat this cycle.
REQ-009 The block SHALL have port out_valid, output, 1, sum result present.
REQ-010 The block SHALL have port out_data, output, WIDTH, sum in sign-magnitude Q7.8.
REQ-011 The block SHALL have port out_ready, input, 1, consumer accepts result.
REQ-012 The block SHALL have port out_sat, output, 1, result was saturated; qualified by out_valid.
REQ-013 The block SHALL have port out_trunc, output, 1, sum force-closed at MAX_TERMS without in_last; qualified by out_valid.

Function
REQ-014 The block SHALL implement FSM states IDLE (accumulator zero), ACCUM (one or more terms summed), HOLD (result presented).
REQ-015 The block SHALL drive in_ready high in IDLE and ACCUM and low in HOLD; a beat is accepted only when in_valid and in_ready are both high.
REQ-016 The block SHALL convert each accepted beat to two's complement (magnitude negated when sign=1) and add it to an internal 24-bit two's-complement accumulator; no intermediate saturation.
REQ-017 The block SHALL treat input 0x8000 (negative zero) as zero.
REQ-018 The block SHALL increment a term counter per accepted beat; transitions: IDLE->ACCUM on a non-last beat, IDLE/ACCUM->HOLD on a last beat or on the MAX_TERMS-th beat.
REQ-019 The block SHALL set out_trunc=1 when HOLD is entered via the MAX_TERMS-th beat with in_last=0, else 0.
REQ-020 The block SHALL assert out_valid the cycle after the closing beat is accepted (latency 1) and hold out_data, out_sat and out_trunc stable while out_valid=1 and out_ready=0.
REQ-021 The block SHALL convert the final sum to sign-magnitude: magnitude above 0x7FFF clamps to 0x7FFF with the sum's sign and out_sat=1; otherwise exact, out_sat=0.
REQ-022 The block SHALL output a zero sum as 0x0000, never 0x8000.
REQ-023 On out_valid and out_ready both high, the block SHALL clear the accumulator, counter and flags and return to IDLE next cycle; in_ready rises that cycle.
REQ-024 The block SHALL ignore in_valid/in_data/in_last while in HOLD; the beats are not consumed.

Reset
REQ-025 When rst_n=0 at a rising edge, the block SHALL enter IDLE, clear accumulator and counter, and drive out_valid=0, out_data=0x0000, out_sat=0, out_trunc=0, in_ready=1 the following cycle.
REQ-026 Reset SHALL take priority over all other activity, including mid-sum and HOLD; partial sums are discarded.

Verification
REQ-027 Single beat 0x04E0 with in_last -> next cycle out_valid=1, out_data=0x04E0, out_sat=0, out_trunc=0.
REQ-028 Beats 0x0180 then 0x8340 (last) -> out_data=0x81C0 (-1.75), out_sat=0.
REQ-029 Beats 0x7FFF then 0x0001 (last) -> out_data=0x7FFF, out_sat=1; beats 0xFFFF then 0x8001 (last) -> out_data=0xFFFF, out_sat=1.
REQ-030 Beats 0x0100 then 0x8100 (last) -> out_data=0x0000; also a single beat 0x8000 (last) -> out_data=0x0000.
REQ-031 Result pending with out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0, out_data unchanged; out_ready=1 -> IDLE, next beat accepted.
REQ-032 Two beats accepted, rst_n=0 one cycle, then 0x0200 (last) -> out_data=0x0200; 256 beats of 0x0001, none last -> out_data=0x0100, out_trunc=1.
